serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Multi-cycle sequencer that adds two WIDTH-bit operands by driving a single 2-bit full-adder slice over successive clock cycles, two bits per cycle, with the carry held in a register between steps. It sits between a requester issuing start/operand pulses and the shared 2-bit adder datapath. It trades latency for area against a full-width ripple adder.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 2. Step count N = WIDTH/2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy = 0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an operation is in progress, including the DONE cycle.
- done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out of bit WIDTH-1; held like sum.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE.
- IDLE:
  - start = 1 → load the A/B shift registers and carry ← cin, set step ← 0, clear the sum register, go to RUN.
  - start = 0 → stay in IDLE.
- RUN, each cycle:
  - The slice adds a[1:0], b[1:0] and carry.
  - The slice's 2-bit sum is shifted into sum from the MSB side; carry ← slice cout.
  - The A/B registers shift right by 2 and step increments.
  - When step = N-1, go to DONE. After exactly N RUN cycles, sum[2k+1:2k] holds slice k.
- DONE:
  - done = 1 for exactly one cycle, then return to IDLE.
  - cout is the final carry register value.
- start while busy = 1 is ignored and not queued. Operand changes after the accepting edge have no effect.
- Arithmetic: {cout, sum} = a + b + cin, exactly, modulo 2^(WIDTH+1).
- Reset at any time, including mid-RUN:
  - State → IDLE; the operation is abandoned with no done pulse.
  - busy, done, sum, cout and ovf all → 0.
  - The step counter, carry and shift registers clear.
- Reset values: busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.

## Timing
- Edge T: start = 1 with busy = 0 is accepted; busy = 1 in the following cycle.
- Edges T+1 … T+N: one slice per edge.
- Edge T+N: transition to DONE; done = 1 and busy = 1 for the cycle between edges T+N and T+N+1.
- Edge T+N+1: back to IDLE with busy = 0; a new start can be accepted at edge T+N+2 at the earliest.
- Throughput is one operation per N+2 cycles when start is held high.
- sum and cout update only during RUN and are stable from done until the next accepted start.
- The slice is purely combinational; no register sits inside it.

## Configuration
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - The ovf port exists.
  - On the last RUN step, ovf ← (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), using the slice's mid carry (c_mid).
  - ovf is held with sum and cleared to 0 on an accepted start.
- Undefined: no ovf port and no overflow logic; all other behaviour is identical.

## Structure
- Package serial_add_pkg:
  - FSM state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - SLICE_W = 2.
  - Helper function for the step-counter width: clog2(WIDTH/2), minimum 1.
- Sub-module add2_slice:
  - Inputs: a[1:0], b[1:0], ci.
  - Outputs: s[1:0], c_mid, co.
  - Built from two 1-bit full adders; c_mid is the carry out of bit 0, co is the carry out of bit 1.
- serial_add_ctrl contains the FSM, step counter, shift registers, carry register and output registers.

## Test plan
- WIDTH = 8, a = 0x3C, b = 0x41, cin = 0 → done exactly 4 edges after the accepting edge; sum = 0x7D, cout = 0, busy high for 5 cycles.
- WIDTH = 8, a = 0xFF, b = 0x01, cin = 0 → sum = 0x00, cout = 1, ovf = 0; also a = 0xFF, b = 0x00, cin = 1 → sum = 0x00, cout = 1.
- With SERIAL_ADD_OVF_EN, WIDTH = 8:
  - a = 0x7F, b = 0x01 → sum = 0x80, ovf = 1, cout = 0.
  - a = 0x80, b = 0x80 → sum = 0x00, ovf = 1, cout = 1.
- start pulsed again 2 cycles after acceptance with different operands → ignored; the result equals the first operation, and exactly one done pulse occurs.
- rst asserted during RUN step 2 → busy, done, sum and cout read 0 immediately with no done pulse; a fresh start after reset release yields the correct sum.
- WIDTH = 2 and WIDTH = 16 with start held high continuously → one done every N+2 cycles; 1000 random operands per width match a + b + cin.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the two-bits-per-cycle serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 2;

    // Step counter width: clog2(WIDTH/2), never narrower than one bit.
    function automatic int step_cnt_w(input int width);
        return ((width / SLICE_W) <= 2) ? 1 : $clog2(width / SLICE_W);
    endfunction

endpackage

// File: rtl/serial_add_add2_slice.sv
// Combinational 2-bit adder slice built from two chained 1-bit full adders.
// Zero latency, no storage; c_mid is the carry between the two bit positions.
module add2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] s,
    output logic       c_mid,
    output logic       co
);

    assign s[0]  = a[0] ^ b[0] ^ ci;
    assign c_mid = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));

    assign s[1]  = a[1] ^ b[1] ^ c_mid;
    assign co    = (a[1] & b[1]) | (c_mid & (a[1] ^ b[1]));

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial WIDTH-bit adder: one 2-bit slice per cycle, done WIDTH/2 edges after accept, starts ignored while busy.
// Signed overflow output is built only when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / SLICE_W;
    localparam int SW = step_cnt_w(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [SW-1:0]    r_step;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_s;
    logic             w_co;
`ifdef SERIAL_ADD_OVF_EN
    logic             w_c_mid;
    logic             r_ovf;
`endif

    add2_slice u_slice (
        .a     (r_a[1:0]),
        .b     (r_b[1:0]),
        .ci    (r_carry),
        .s     (w_s),
`ifdef SERIAL_ADD_OVF_EN
        .c_mid (w_c_mid),
`else
        .c_mid (),
`endif
        .co    (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_step  <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_step  <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
`ifdef SERIAL_ADD_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    // New slice enters at the MSB end so slice k lands at [2k+1:2k] after N steps.
                    r_sum   <= WIDTH'({w_s, r_sum} >> SLICE_W);
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_carry <= w_co;
                    r_cout  <= w_co;
                    r_step  <= r_step + SW'(1);
                    if (r_step == SW'(N - 1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        r_ovf   <= w_c_mid ^ w_co;
`endif
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH 2, 8 and 16 against an arithmetic reference model.
// Build with SERIAL_ADD_OVF_EN defined to also check the overflow output.
module tb_serial_add_ctrl;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0]   a_i   [NI];
    logic [15:0]   b_i   [NI];
    logic          cin_i [NI];
    logic          start_i [NI];
    logic [NI-1:0] busy_o;
    logic [NI-1:0] done_o;
    logic [NI-1:0] cout_o;
    logic [1:0]    sum2;
    logic [7:0]    sum8;
    logic [15:0]   sum16;
    logic [15:0]   sum_o [NI];
`ifdef SERIAL_ADD_OVF_EN
    logic [NI-1:0] ovf_o;
`endif

    assign sum_o[0] = {14'd0, sum2};
    assign sum_o[1] = {8'd0, sum8};
    assign sum_o[2] = sum16;

    serial_add_ctrl #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .start(start_i[0]), .a(a_i[0][1:0]), .b(b_i[0][1:0]),
        .cin(cin_i[0]), .busy(busy_o[0]), .done(done_o[0]), .sum(sum2), .cout(cout_o[0])
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf_o[0])
`endif
    );

    serial_add_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_i[1]), .a(a_i[1][7:0]), .b(b_i[1][7:0]),
        .cin(cin_i[1]), .busy(busy_o[1]), .done(done_o[1]), .sum(sum8), .cout(cout_o[1])
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf_o[1])
`endif
    );

    serial_add_ctrl #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start(start_i[2]), .a(a_i[2]), .b(b_i[2]),
        .cin(cin_i[2]), .busy(busy_o[2]), .done(done_o[2]), .sum(sum16), .cout(cout_o[2])
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf_o[2])
`endif
    );

    function automatic int wid(input int i);
        return (i == 0) ? 2 : (i == 1) ? 8 : 16;
    endfunction

    // Exact {cout, sum} = a + b + cin for a width-w add.
    function automatic logic [16:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        longint m = (64'd1 << w) - 1;
        longint s = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
        return 17'(s);
    endfunction

    // Overflow: the true signed sum does not fit in w bits.
    function automatic logic ref_ovf(input int w, input logic [15:0] a, input logic [15:0] b,
                                     input logic cin);
        longint m  = (64'd1 << w) - 1;
        longint ua = longint'(a) & m;
        longint ub = longint'(b) & m;
        longint sa = (ua >= (64'd1 << (w - 1))) ? ua - (64'd1 << w) : ua;
        longint sb = (ub >= (64'd1 << (w - 1))) ? ub - (64'd1 << w) : ub;
        longint s  = sa + sb + longint'(cin);
        return (s > ((64'd1 << (w - 1)) - 1)) || (s < -(64'sd1 << (w - 1)));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_cnt counts remaining busy cycles; 1 means the done cycle.
    int          m_cnt  [NI] = '{default: 0};
    logic [16:0] m_res  [NI] = '{default: '0};
    logic [16:0] m_held [NI] = '{default: '0};
    logic        m_ovfr [NI] = '{default: 1'b0};
    logic        m_ovfh [NI] = '{default: 1'b0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_cnt[i]  = 0;
                m_held[i] = '0;
                m_ovfh[i] = 1'b0;
            end else if (m_cnt[i] == 0) begin
                if (start_i[i]) begin
                    m_cnt[i]  = wid(i) / 2 + 1;
                    m_res[i]  = ref_add(wid(i), a_i[i], b_i[i], cin_i[i]);
                    m_ovfr[i] = ref_ovf(wid(i), a_i[i], b_i[i], cin_i[i]);
                end
            end else begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 1) begin
                    m_held[i] = m_res[i];
                    m_ovfh[i] = m_ovfr[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("w%0d_busy", wid(i)), 64'(busy_o[i]), 64'(m_cnt[i] > 0));
            chk($sformatf("w%0d_done", wid(i)), 64'(done_o[i]), 64'(m_cnt[i] == 1));
            if (m_cnt[i] <= 1) begin
                chk($sformatf("w%0d_sum", wid(i)), 64'(sum_o[i]),
                    64'(m_held[i] & ((17'd1 << wid(i)) - 17'd1)));
                chk($sformatf("w%0d_cout", wid(i)), 64'(cout_o[i]), 64'(m_held[i][wid(i)]));
`ifdef SERIAL_ADD_OVF_EN
                chk($sformatf("w%0d_ovf", wid(i)), 64'(ovf_o[i]), 64'(m_ovfh[i]));
`endif
            end
        end
    end

    int lat, busyc, donec;

    // Runs one WIDTH=8 operation. mode 1: second start with other operands two cycles in;
    // mode 2: reset asserted during RUN step 2.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input int mode);
        int guard = 0;
        while (busy_o[1] && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        a_i[1] = {8'd0, a}; b_i[1] = {8'd0, b}; cin_i[1] = cin; start_i[1] = 1'b1;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        a_i[1] = 16'($urandom); b_i[1] = 16'($urandom); cin_i[1] = 1'($urandom_range(0, 1));
        lat = 0; busyc = int'(busy_o[1]); donec = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            start_i[1] = 1'b0;
            if (busy_o[1]) busyc++;
            if (done_o[1]) begin
                donec++;
                if (lat == 0) lat = c;
            end
            if (mode == 1 && c == 1) begin
                a_i[1] = {8'd0, ~a}; b_i[1] = {8'd0, a}; cin_i[1] = ~cin; start_i[1] = 1'b1;
            end
            if (mode == 2 && c == 2) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_mid_busy", 64'(busy_o[1]), 64'd0);
                chk("rst_mid_done", 64'(done_o[1]), 64'd0);
                chk("rst_mid_sum",  64'(sum8), 64'd0);
                chk("rst_mid_cout", 64'(cout_o[1]), 64'd0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
        end
        if (mode != 2 && lat == 0) chk("op8_done_timeout", 64'd0, 64'd1);
    endtask

    int nd [NI];
    int first_d [NI];
    int last_d [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            a_i[i] = '0; b_i[i] = '0; cin_i[i] = 1'b0; start_i[i] = 1'b0;
            nd[i] = 0; first_d[i] = 0; last_d[i] = 0;
        end
        #2;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_sum8", 64'(sum8), 64'd0);
        chk("reset_cout", 64'(cout_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        op8(8'h3C, 8'h41, 1'b0, 0);
        chk("t1_latency", 64'(lat), 64'd4);
        chk("t1_busy_cycles", 64'(busyc), 64'd5);
        chk("t1_done_count", 64'(donec), 64'd1);
        chk("t1_sum", 64'(sum8), 64'h7D);
        chk("t1_cout", 64'(cout_o[1]), 64'd0);

        op8(8'hFF, 8'h01, 1'b0, 0);
        chk("t2_sum", 64'(sum8), 64'h00);
        chk("t2_cout", 64'(cout_o[1]), 64'd1);
`ifdef SERIAL_ADD_OVF_EN
        chk("t2_ovf", 64'(ovf_o[1]), 64'd0);
`endif

        op8(8'hFF, 8'h00, 1'b1, 0);
        chk("t3_sum", 64'(sum8), 64'h00);
        chk("t3_cout", 64'(cout_o[1]), 64'd1);

        op8(8'h7F, 8'h01, 1'b0, 0);
        chk("t4_sum", 64'(sum8), 64'h80);
        chk("t4_cout", 64'(cout_o[1]), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("t4_ovf", 64'(ovf_o[1]), 64'd1);
`endif

        op8(8'h80, 8'h80, 1'b0, 0);
        chk("t5_sum", 64'(sum8), 64'h00);
        chk("t5_cout", 64'(cout_o[1]), 64'd1);
`ifdef SERIAL_ADD_OVF_EN
        chk("t5_ovf", 64'(ovf_o[1]), 64'd1);
`endif

        op8(8'h12, 8'h34, 1'b1, 1);
        chk("t6_done_count", 64'(donec), 64'd1);
        chk("t6_sum", 64'(sum8), 64'h47);
        chk("t6_cout", 64'(cout_o[1]), 64'd0);

        op8(8'hA5, 8'h5A, 1'b0, 2);
        chk("t7_no_done", 64'(donec), 64'd0);

        op8(8'h99, 8'h77, 1'b1, 0);
        chk("t8_sum", 64'(sum8), 64'h11);
        chk("t8_cout", 64'(cout_o[1]), 64'd1);

        // Streaming: start held high, operands re-randomized every cycle.
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) start_i[i] = 1'b1;
        for (int cyc = 0; cyc < 14000 && (nd[0] < 1000 || nd[2] < 1000); cyc++) begin
            for (int i = 0; i < NI; i++) begin
                a_i[i] = 16'($urandom); b_i[i] = 16'($urandom);
                cin_i[i] = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (done_o[i]) begin
                    if (nd[i] == 0) first_d[i] = cyc;
                    last_d[i] = cyc;
                    nd[i]++;
                end
            end
        end
        for (int i = 0; i < NI; i++) start_i[i] = 1'b0;
        chk("w2_ops", 64'(nd[0] >= 1000), 64'd1);
        chk("w16_ops", 64'(nd[2] >= 1000), 64'd1);
        chk("w2_period", 64'(last_d[0] - first_d[0]), 64'((nd[0] - 1) * 3));
        chk("w16_period", 64'(last_d[2] - first_d[2]), 64'((nd[2] - 1) * 10));
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
